// File: rtl/config_frame_writer.sv
// Configuration frame writer: parses a SYNC / address / data word stream from a valid-ready port
// and pulses one latch-row strobe per frame while the frame word is held stable on the columns.
module config_frame_writer #(
    parameter int FRAME_BITS    = 32,
    parameter int NUM_FRAMES    = 20,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic [FRAME_BITS-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [NUM_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STROBE,
        HOLD
    } state_t;

    localparam logic [FRAME_BITS-1:0] SYNC_WORD   = FRAME_BITS'(32'hFAB0_FAB1);
    localparam logic [FRAME_BITS-1:0] DESYNC_WORD = FRAME_BITS'(32'hFAB0_FAB0);
    localparam logic [7:0]            LAST_IDX    = 8'(NUM_FRAMES - 1);
    localparam logic [3:0]            STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              idx;
    logic [7:0]              idx_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;
    logic [FRAME_BITS-1:0]   data_q;
    logic [FRAME_BITS-1:0]   data_next;
    logic [NUM_FRAMES-1:0]   strobe_q;
    logic [NUM_FRAMES-1:0]   strobe_next;
    logic                    err_q;
    logic                    err_next;
    logic [15:0]             count_q;
    logic [15:0]             count_next;
    logic                    busy_q;
    logic                    busy_next;
    logic                    xfer;
    logic                    idx_in_range;

    function automatic logic [NUM_FRAMES-1:0] decode_idx(input logic [7:0] row);
        logic [NUM_FRAMES-1:0] onehot;
        onehot = '0;
        for (int k = 0; k < NUM_FRAMES; k++) begin
            onehot[k] = (row == 8'(k));
        end
        return onehot;
    endfunction

    // Ready depends only on state (and is forced low while reset is held).
    assign s_ready      = resetn && (state == IDLE || state == ADDR || state == DATA);
    assign xfer         = s_valid && s_ready;
    assign idx_in_range = (idx <= LAST_IDX);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            cnt      <= cnt_next;
            data_q   <= data_next;
            strobe_q <= strobe_next;
            err_q    <= err_next;
            count_q  <= count_next;
            busy_q   <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer && s_data == SYNC_WORD) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (xfer) begin
                    state_next = (s_data == DESYNC_WORD) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    state_next = idx_in_range ? STROBE : ADDR;
                end
            end
            STROBE: begin
                if (cnt == STROBE_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD:    state_next = ADDR;
            default: state_next = IDLE;
        endcase
    end

    // Next values for every registered output; the strobe is built here so it is
    // already one-hot in the first STROBE cycle and drops exactly when HOLD begins.
    always_comb begin
        idx_next    = idx;
        cnt_next    = cnt;
        data_next   = data_q;
        strobe_next = '0;
        err_next    = err_q;
        count_next  = count_q;
        case (state)
            ADDR: begin
                if (xfer && s_data != DESYNC_WORD) begin
                    idx_next = s_data[7:0];
                end
            end
            DATA: begin
                if (xfer) begin
                    if (idx_in_range) begin
                        data_next   = s_data;
                        strobe_next = decode_idx(idx);
                        cnt_next    = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (cnt != STROBE_LAST) begin
                    strobe_next = strobe_q;
                    cnt_next    = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (count_q != 16'hFFFF) begin
                    count_next = count_q + 16'd1;
                end
            end
            default: begin
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer: directed frames push expected strobe/data pairs,
// a negedge monitor pops them on each strobe pulse and checks pulse shape and ready timing.
module tb_config_frame_writer;

    localparam int FRAME_BITS    = 32;
    localparam int NUM_FRAMES    = 20;
    localparam int STROBE_CYCLES = 2;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic                  CLK = 1'b0;
    logic                  resetn;
    logic [FRAME_BITS-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [FRAME_BITS-1:0] FrameData;
    logic [NUM_FRAMES-1:0] FrameStrobe;
    logic                  busy;
    logic                  err;
    logic [15:0]           frame_count;

    typedef struct {
        logic [NUM_FRAMES-1:0] strobe;
        logic [FRAME_BITS-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    config_frame_writer #(
        .FRAME_BITS   (FRAME_BITS),
        .NUM_FRAMES   (NUM_FRAMES),
        .STROBE_CYCLES(STROBE_CYCLES)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .busy       (busy),
        .err        (err),
        .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no response, expected one within the cycle budget", name);
    endtask

    task automatic pushExp(input logic [7:0] row, input logic [31:0] data);
        exp_t e;
        e.strobe = NUM_FRAMES'(1) << row;
        e.data   = data;
        expQ.push_back(e);
    endtask

    // Called at a rising edge; leaves s_valid high so back-to-back calls stream continuously.
    task automatic applyStimulus(input logic [31:0] word);
        logic wasReady;
        bit   done;
        done = 1'b0;
        #1;
        s_data  = word;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            wasReady = s_ready;
            @(posedge CLK);
            if (wasReady) done = 1'b1;
        end
        if (!done) reportTimeout("handshake_timeout");
    endtask

    task automatic releaseBus();
        #1;
        s_valid = 1'b0;
    endtask

    task automatic waitReady();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (s_ready) seen = 1'b1;
        end
        if (!seen) reportTimeout("ready_timeout");
    endtask

    task automatic writeFrame(input logic [7:0] row, input logic [31:0] data);
        if (row < NUM_FRAMES) pushExp(row, data);
        applyStimulus({24'h0, row});
        applyStimulus(data);
    endtask

    bit                    inPulse        = 1'b0;
    bit                    pulseAborted   = 1'b0;
    bit                    prevStrobeHigh = 1'b0;
    int                    runLen         = 0;
    logic [NUM_FRAMES-1:0] pulseStrobe;
    logic [FRAME_BITS-1:0] pulseData;
    exp_t                  got;

    // Monitor: pops one expectation per strobe pulse; s_ready must be low during STROBE and the HOLD cycle after it.
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            checkOutput("strobe_onehot", 64'($onehot(FrameStrobe)), 64'(1));
            if (!resetn) pulseAborted = 1'b1;
            if (!inPulse) begin
                inPulse     = 1'b1;
                runLen      = 1;
                pulseStrobe = FrameStrobe;
                pulseData   = FrameData;
                if (expQ.size() == 0) begin
                    reportTimeout("unexpected_strobe");
                end else begin
                    got = expQ.pop_front();
                    checkOutput("frame_strobe", 64'(FrameStrobe), 64'(got.strobe));
                    checkOutput("frame_data", 64'(FrameData), 64'(got.data));
                end
            end else begin
                runLen++;
                checkOutput("strobe_stable", 64'(FrameStrobe), 64'(pulseStrobe));
                checkOutput("data_stable", 64'(FrameData), 64'(pulseData));
            end
        end else if (inPulse) begin
            inPulse = 1'b0;
            if (!pulseAborted) checkOutput("strobe_len", 64'(runLen), 64'(STROBE_CYCLES));
            pulseAborted = 1'b0;
        end
        if (!resetn) begin
            checkOutput("ready_in_reset", 64'(s_ready), 64'(0));
        end else begin
            checkOutput("ready_timing", 64'(s_ready), 64'(!((FrameStrobe != '0) || prevStrobeHigh)));
        end
        prevStrobeHigh = (FrameStrobe != '0);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_strobe", 64'(FrameStrobe), 64'(0));
        checkOutput("rst_data", 64'(FrameData), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_count", 64'(frame_count), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        @(posedge CLK);
        #1 resetn = 1'b1;
        @(negedge CLK);
        checkOutput("ready_after_release", 64'(s_ready), 64'(1));
        @(posedge CLK);

        // Garbage in IDLE is dropped, then a normal frame to row 3.
        applyStimulus(32'h1234_5678);
        releaseBus();
        @(negedge CLK);
        checkOutput("idle_after_garbage", 64'(busy), 64'(0));
        @(posedge CLK);
        applyStimulus(SYNC);
        writeFrame(8'd3, 32'hA5A5_0F0F);
        releaseBus();
        waitReady();
        checkOutput("count_frame1", 64'(frame_count), 64'(1));
        checkOutput("err_frame1", 64'(err), 64'(0));
        checkOutput("busy_in_addr", 64'(busy), 64'(1));
        checkOutput("data_frame1", 64'(FrameData), 64'(32'hA5A5_0F0F));
        @(posedge CLK);

        // Out-of-range row sets err without touching data or count; next frame still works.
        writeFrame(8'd25, 32'hDEAD_BEEF);
        releaseBus();
        waitReady();
        checkOutput("err_set", 64'(err), 64'(1));
        checkOutput("count_after_err", 64'(frame_count), 64'(1));
        checkOutput("data_after_err", 64'(FrameData), 64'(32'hA5A5_0F0F));
        @(posedge CLK);
        writeFrame(8'd0, 32'h1111_2222);
        releaseBus();
        waitReady();
        checkOutput("count_after_row0", 64'(frame_count), 64'(2));
        checkOutput("err_sticky", 64'(err), 64'(1));
        @(posedge CLK);

        // A stall between address and data words must simply wait.
        pushExp(8'd5, 32'h0BAD_F00D);
        applyStimulus(32'h0000_0005);
        releaseBus();
        repeat (5) @(negedge CLK);
        checkOutput("stall_busy", 64'(busy), 64'(1));
        checkOutput("stall_ready", 64'(s_ready), 64'(1));
        checkOutput("stall_no_strobe", 64'(FrameStrobe), 64'(0));
        @(posedge CLK);
        applyStimulus(32'h0BAD_F00D);
        releaseBus();
        waitReady();
        checkOutput("count_after_stall", 64'(frame_count), 64'(3));
        @(posedge CLK);

        // Continuous valid across rows 0, 1, 2.
        for (int r = 0; r < 3; r++) begin
            writeFrame(8'(r), 32'hC0DE_0000 + 32'(r));
        end
        releaseBus();
        waitReady();
        checkOutput("count_stream", 64'(frame_count), 64'(6));
        checkOutput("data_stream", 64'(FrameData), 64'(32'hC0DE_0002));
        @(posedge CLK);

        // DESYNC returns to IDLE; later words are discarded and nothing strobes.
        applyStimulus(DESYNC);
        releaseBus();
        @(negedge CLK);
        checkOutput("desync_busy", 64'(busy), 64'(0));
        @(posedge CLK);
        applyStimulus(32'h0000_0007);
        applyStimulus(32'h0000_0055);
        releaseBus();
        repeat (8) @(negedge CLK);
        checkOutput("desync_idle_busy", 64'(busy), 64'(0));
        checkOutput("desync_count", 64'(frame_count), 64'(6));
        @(posedge CLK);

        // Reset during the first strobe cycle aborts the frame.
        applyStimulus(SYNC);
        writeFrame(8'd4, 32'h4444_4444);
        #1;
        resetn  = 1'b0;
        s_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("abort_strobe", 64'(FrameStrobe), 64'(0));
        checkOutput("abort_count", 64'(frame_count), 64'(0));
        checkOutput("abort_err", 64'(err), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_data", 64'(FrameData), 64'(0));
        @(posedge CLK);
        #1 resetn = 1'b1;
        @(negedge CLK);
        checkOutput("ready_after_abort", 64'(s_ready), 64'(1));
        @(posedge CLK);

        // Boundary rows: 19 is the last valid row, 20 is the first invalid one.
        applyStimulus(SYNC);
        writeFrame(8'd19, 32'h1313_1313);
        writeFrame(8'd20, 32'h1414_1414);
        releaseBus();
        waitReady();
        checkOutput("count_boundary", 64'(frame_count), 64'(1));
        checkOutput("err_boundary", 64'(err), 64'(1));
        checkOutput("data_boundary", 64'(FrameData), 64'(32'h1313_1313));

        repeat (4) @(negedge CLK);
        checkOutput("queue_drained", 64'(expQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
